serial_cla_add12: RTL and testbench
===================================

SERIAL_CLA_ADD12 -- requirements
Module: serial_cla_add12

Interface
REQ-001 Parameter: NSLICE, default 4, number of 3-bit slices; operand width W = 3*NSLICE (12 at default).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to begin one addition; sampled only in IDLE.
REQ-005 Port: clr  input  1  synchronous abort; returns block to IDLE.
REQ-006 Port: A  input  W  operand A; captured on accepted start.
REQ-007 Port: B  input  W  operand B; captured on accepted start.
REQ-008 Port: Cin  input  1  carry-in; captured on accepted start.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse; high only in DONE.
REQ-011 Port: S  output  W+1  registered sum; S[W] is final carry-out.

Function
REQ-012 The block SHALL reuse one internal combinational 3-bit carry-lookahead slice (per-bit G=A&B, P=A^B, lookahead carries, sum = P^carry) across NSLICE cycles; no full-width adder SHALL be built.
REQ-013 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 and clr=0 at an edge SHALL capture A, B, Cin into internal registers, clear S to 0, set slice index k=0, go to RUN.
REQ-015 IDLE: start=0 SHALL hold state; S keeps its last value.
REQ-016 RUN: each edge SHALL add slice k (bits 3k+2..3k) of captured A and B plus carry register, write the 3 sum bits into S[3k+2:3k], load the slice carry-out into the carry register, and increment k.
REQ-017 RUN: on the edge processing k=NSLICE-1 the block SHALL also write the final carry into S[W] and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; next edge SHALL go to IDLE unconditionally.
REQ-019 Latency: with start accepted at edge t, S SHALL be complete and done=1 in the cycle after edge t+NSLICE (done high 5 cycles after accept at default).
REQ-020 start while in RUN or DONE SHALL be ignored and not queued; captured operands SHALL NOT change mid-operation.
REQ-021 A, B, Cin changes after acceptance SHALL NOT affect the result.
REQ-022 clr=1 in any state SHALL force IDLE at the next edge, clear k and carry register, suppress done; S holds the partial value; clr has priority over start.
REQ-023 busy SHALL be 1 exactly in RUN; busy and done SHALL never both be 1.
REQ-024 Arithmetic SHALL be unsigned: S = A + B + Cin modulo 2^(W+1), no overflow loss.
REQ-025 Back-to-back: start may be accepted in the IDLE cycle immediately following DONE; minimum issue interval NSLICE+2 cycles.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force state IDLE, k=0, carry register 0, captured operands 0, S=0, busy=0, done=0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.

Verification
REQ-028 A=0xFFF, B=0x001, Cin=0, start -> busy 4 cycles, done pulse, S=0x1000.
REQ-029 A=0xFFF, B=0xFFF, Cin=1 -> S=0x1FFF with done exactly 5 cycles after accept.
REQ-030 A=0x5A3, B=0x2C4, Cin=0; change A/B to 0x000 during RUN -> S=0x867 (changes ignored).
REQ-031 Second start pulsed during RUN and DONE -> ignored, single done pulse; start in next IDLE -> new result correct.
REQ-032 clr at 2nd RUN cycle -> IDLE next edge, no done, busy low; rst at 3rd RUN cycle -> S=0, outputs 0 immediately.
REQ-033 Random A, B, Cin (>=1000 ops, including back-to-back) -> S equals A+B+Cin for every done pulse.

Source files
------------

// File: rtl/serial_cla_add12.sv
// rtl/serial_cla_add12.sv - bit-serial-by-slice adder reusing one 3-bit carry-lookahead slice
module serial_cla_add12 #(
    parameter int NSLICE = 4,
    localparam int W = 3 * NSLICE,
    localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [W:0]   S
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic          carry;
    logic [KW-1:0] k;

    logic [2:0] sa, sb, g, p, sum;
    logic       c1, c2, c3;

    // The single shared lookahead slice, fed by the slice selected by k.
    always_comb begin
        sa  = a_r[int'(k) * 3 +: 3];
        sb  = b_r[int'(k) * 3 +: 3];
        g   = sa & sb;
        p   = sa ^ sb;
        c1  = g[0] | (p[0] & carry);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
        sum = p ^ {c2, c1, carry};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            k     <= '0;
            S     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            // Abort keeps the partial sum visible; only sequencing state is cleared.
            state <= IDLE;
            carry <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r   <= A;
                        b_r   <= B;
                        carry <= Cin;
                        S     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    S[int'(k) * 3 +: 3] <= sum;
                    carry <= c3;
                    if (k == KW'(NSLICE - 1)) begin
                        S[W]  <= c3;
                        k     <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_cla_add12.sv
// tb/tb_serial_cla_add12.sv - directed and random checks for serial_cla_add12
module tb_serial_cla_add12;

    logic        clk;
    logic        rst;
    logic        start;
    logic        clr;
    logic [11:0] A;
    logic [11:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [12:0] S;

    int checks = 0;
    int errors = 0;

    serial_cla_add12 dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .S(S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one start in IDLE and returns one cycle after the accepting edge.
    task automatic start_op(input logic [11:0] a, input logic [11:0] b, input logic c);
        A = a; B = b; Cin = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // lat counts cycles from the start-presenting cycle to the done cycle.
    task automatic wait_done(output int lat, output int bcy);
        lat = 1;
        bcy = 0;
        while (!done && lat < 20) begin
            if (busy) bcy++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clr = 1'b0; A = '0; B = '0; Cin = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (S !== 13'h0) begin errors++; $display("FAIL reset_s got %h want 0000", S); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_carry_ripple();
        int lat, bcy;
        start_op(12'hFFF, 12'h001, 1'b0);
        wait_done(lat, bcy);
        checks++; if (bcy != 4) begin errors++; $display("FAIL ripple_busy_cycles got %0d want 4", bcy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ripple_done got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ripple_busy_in_done got %b want 0", busy); end
        checks++; if (S !== 13'h1000) begin errors++; $display("FAIL ripple_sum got %h want 1000", S); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ripple_done_pulse got %b want 0", done); end
    endtask

    task automatic test_max_latency();
        int lat, bcy;
        start_op(12'hFFF, 12'hFFF, 1'b1);
        wait_done(lat, bcy);
        checks++; if (lat != 5) begin errors++; $display("FAIL max_latency got %0d want 5", lat); end
        checks++; if (S !== 13'h1FFF) begin errors++; $display("FAIL max_sum got %h want 1fff", S); end
        tick();
    endtask

    task automatic test_input_change();
        int lat, bcy;
        start_op(12'h5A3, 12'h2C4, 1'b0);
        A = 12'h000; B = 12'h000; Cin = 1'b1;
        wait_done(lat, bcy);
        checks++; if (S !== 13'h0867) begin errors++; $display("FAIL input_change_sum got %h want 0867", S); end
        tick();
    endtask

    task automatic test_ignored_start();
        int lat, bcy, npulse;
        npulse = 0;
        start_op(12'h0F0, 12'h00F, 1'b0);
        A = 12'h001; B = 12'h001;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            if (done) npulse++;
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done) npulse++;
            tick();
        end
        checks++; if (npulse != 1) begin errors++; $display("FAIL ignored_start_pulses got %0d want 1", npulse); end
        checks++; if (S !== 13'h00FF) begin errors++; $display("FAIL ignored_start_sum got %h want 00ff", S); end
        start_op(12'h123, 12'h456, 1'b0);
        wait_done(lat, bcy);
        checks++; if (S !== 13'h0579) begin errors++; $display("FAIL ignored_start_next got %h want 0579", S); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bcy;
        start_op(12'h800, 12'h800, 1'b0);
        wait_done(lat, bcy);
        checks++; if (S !== 13'h1000) begin errors++; $display("FAIL b2b_first got %h want 1000", S); end
        A = 12'h00A; B = 12'h005; Cin = 1'b1; start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy); end
        wait_done(lat, bcy);
        checks++; if (S !== 13'h0010) begin errors++; $display("FAIL b2b_second got %h want 0010", S); end
        tick();
    endtask

    task automatic test_clr();
        int lat, bcy, npulse;
        npulse = 0;
        start_op(12'h5A3, 12'h2C4, 1'b1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
        checks++; if (S !== 13'h0000) begin errors++; $display("FAIL clr_partial got %h want 0000", S); end
        for (int i = 0; i < 6; i++) begin
            if (done) npulse++;
            tick();
        end
        checks++; if (npulse != 0) begin errors++; $display("FAIL clr_no_done got %0d want 0", npulse); end
        start_op(12'h001, 12'h001, 1'b0);
        wait_done(lat, bcy);
        checks++; if (S !== 13'h0002) begin errors++; $display("FAIL clr_recover got %h want 0002", S); end
        tick();
    endtask

    task automatic test_rst_mid_run();
        int lat, bcy;
        start_op(12'hABC, 12'h123, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++; if (S !== 13'h0) begin errors++; $display("FAIL rst_mid_s got %h want 0000", S); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got busy=%b done=%b want 0 0", busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got %b want 0", done); end
        start_op(12'hABC, 12'h123, 1'b0);
        wait_done(lat, bcy);
        checks++; if (S !== 13'h0BDF) begin errors++; $display("FAIL rst_recover got %h want 0bdf", S); end
        tick();
    endtask

    task automatic test_random();
        int lat, bcy;
        logic [11:0] a, b;
        logic        c;
        logic [12:0] exp;
        for (int n = 0; n < 1000; n++) begin
            a = 12'($urandom_range(0, 4095));
            b = 12'($urandom_range(0, 4095));
            c = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {12'b0, c};
            start_op(a, b, c);
            wait_done(lat, bcy);
            checks++; if (S !== exp || lat != 5) begin
                errors++; $display("FAIL random_op%0d got %h lat %0d want %h lat 5", n, S, lat, exp);
            end
            tick();
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_max_latency();
        test_input_change();
        test_ignored_start();
        test_back_to_back();
        test_clr();
        test_rst_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
